joypad_scanner: RTL

JOYPAD_SCANNER -- requirements
Module: joypad_scanner

---
 rtl/joypad_scanner.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/joypad_scanner.sv
// Serial game-pad scanner with a Game Boy style P1 (0xFF00) register view.
// A poll timer periodically latches the pad, clocks out eight button bits,
// and publishes them atomically; the CPU selects key groups through P1 and
// receives an interrupt on any newly asserted (high-to-low) P1 input line.
module joypad_scanner #(
  parameter int unsigned CLK_DIV     = 100,
  parameter int unsigned POLL_PERIOD = 550000
) (
  input  logic       clock,
  input  logic       reset,
  output logic       latch,
  output logic       pulse,
  input  logic       data,
  input  logic       p1_we,
  input  logic [7:0] p1_wdata,
  output logic [7:0] p1_rdata,
  output logic       joypad_int,
  output logic [7:0] buttons,
  output logic       scan_done
);

  localparam int unsigned        CNT_W      = 20;
  localparam logic [CNT_W-1:0]   POLL_LAST  = CNT_W'(POLL_PERIOD - 1);
  localparam logic [CNT_W-1:0]   LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    PULSE_HI,
    PULSE_LO,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       buttons_q, buttons_d;
  logic             latch_q, latch_d;
  logic             pulse_q, pulse_d;
  logic             scan_done_q, scan_done_d;
  logic             sync1_q, sync2_q;
  logic [1:0]       select_q, select_d;
  logic [3:0]       prev_low_q, prev_low_d;
  logic             int_q, int_d;

  logic [3:0]       dirs;
  logic [3:0]       keys;
  logic [3:0]       low_n;

  // P1 only implements the two select bits; the rest of the write data is dropped.
  logic unused_wdata_bits;
  assign unused_wdata_bits = ^{p1_wdata[7:6], p1_wdata[3:0]};

  // Scan sequencer: poll timer, latch strobe, shift clock and bit capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    buttons_d   = buttons_q;
    latch_d     = 1'b0;
    pulse_d     = 1'b0;
    scan_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnt_q == POLL_LAST) begin
          state_d = LATCH;
          cnt_d   = '0;
          latch_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          shift_d[0] = ~sync2_q;
          bit_d      = 3'd1;
          cnt_d      = '0;
          state_d    = PULSE_HI;
          pulse_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          latch_d = 1'b1;
        end
      end
      PULSE_HI: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = PULSE_LO;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          pulse_d = 1'b1;
        end
      end
      PULSE_LO: begin
        if (cnt_q == HALF_LAST) begin
          shift_d[bit_q] = ~sync2_q;
          cnt_d          = '0;
          if (bit_q == 3'd7) begin
            // Publish including the bit captured on this very edge.
            state_d     = DONE;
            buttons_d   = shift_d;
            scan_done_d = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = PULSE_HI;
            pulse_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // P1 view: active-low lines, a line is low when any enabled mapped key is pressed.
  always_comb begin
    select_d = p1_we ? p1_wdata[5:4] : select_q;
    dirs     = {buttons_q[5], buttons_q[4], buttons_q[6], buttons_q[7]};
    keys     = buttons_q[3:0];
    low_n    = ~((select_q[0] ? 4'h0 : dirs) | (select_q[1] ? 4'h0 : keys));
    prev_low_d = low_n;
    int_d      = |(prev_low_q & ~low_n);
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      buttons_q   <= '0;
      latch_q     <= 1'b0;
      pulse_q     <= 1'b0;
      scan_done_q <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      select_q    <= 2'b11;
      prev_low_q  <= '1;
      int_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      buttons_q   <= buttons_d;
      latch_q     <= latch_d;
      pulse_q     <= pulse_d;
      scan_done_q <= scan_done_d;
      sync1_q     <= data;
      sync2_q     <= sync1_q;
      select_q    <= select_d;
      prev_low_q  <= prev_low_d;
      int_q       <= int_d;
    end
  end

  assign latch      = latch_q;
  assign pulse      = pulse_q;
  assign buttons    = buttons_q;
  assign scan_done  = scan_done_q;
  assign joypad_int = int_q;
  assign p1_rdata   = {2'b11, select_q, low_n};

endmodule
